// File: rtl/wb_copy_master_pkg.sv
// wb_copy_master_pkg: shared state encodings and Wishbone constants for the bus initiators.
package wb_copy_master_pkg;
    typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, ABORT} state_t;
    localparam int WB_SEL_W = 4;
    localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = '1;
endpackage

// File: rtl/wb_copy_master_if.sv
// wb_copy_master_if: Wishbone classic bus between an initiator and the system interconnect.
interface wb_copy_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic [AW-1:0]   wb_adr_o;
    logic [DW-1:0]   wb_dat_o;
    logic [DW-1:0]   wb_dat_i;
    logic            wb_we_o;
    logic [DW/8-1:0] wb_sel_o;
    logic            wb_cyc_o;
    logic            wb_stb_o;
    logic            wb_ack_i;
    modport master (
        output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );
    modport slave (
        input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wb_copy_master_watchdog.sv
// wb_watchdog: counts wait cycles in a bus phase and flags expiry after TIMEOUT cycles without ack.
module wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic wb_clk_i,
    input  logic wb_reset_i,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    logic [15:0] cnt;
    always_ff @(posedge wb_clk_i or posedge wb_reset_i)
        if (wb_reset_i) cnt <= '0;
        else if (clear) cnt <= '0;
        else if (enable) cnt <= cnt + 16'd1;
    // the current cycle is the TIMEOUT-th wait cycle of this phase
    assign expired = enable && cnt == 16'(TIMEOUT - 1);
endmodule

// File: rtl/wb_copy_master.sv
// wb_copy_master: Wishbone classic initiator copying a block of words, one read then one write per word.
module wb_copy_master
    import wb_copy_master_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_reset_i,
    input  logic [AW-1:0]    cmd_src_i,
    input  logic [AW-1:0]    cmd_dst_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             cmd_start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    wb_copy_master_if.master wb
);
    state_t           state;
    logic [AW-1:0]    src, dst;
    logic [LEN_W-1:0] cnt;
    logic             in_phase, expired;
    assign in_phase = state == READ || state == WRITE;
    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
        .wb_clk_i  (wb_clk_i),
        .wb_reset_i(wb_reset_i),
        .clear     (!in_phase || wb.wb_ack_i),
        .enable    (in_phase),
        .expired   (expired)
    );
    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            state       <= IDLE;
            src         <= '0;
            dst         <= '0;
            cnt         <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            error_o     <= 1'b0;
            wb.wb_adr_o <= '0;
            wb.wb_dat_o <= '0;
            wb.wb_we_o  <= 1'b0;
            wb.wb_sel_o <= '0;
            wb.wb_cyc_o <= 1'b0;
            wb.wb_stb_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: if (cmd_start_i) begin
                    src     <= cmd_src_i;
                    dst     <= cmd_dst_i;
                    cnt     <= cmd_len_i;
                    error_o <= 1'b0;
                    busy_o  <= 1'b1;
                    if (cmd_len_i == '0) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end else begin
                        state       <= READ;
                        wb.wb_adr_o <= cmd_src_i;
                        wb.wb_we_o  <= 1'b0;
                        wb.wb_sel_o <= WB_SEL_ALL;
                        wb.wb_cyc_o <= 1'b1;
                        wb.wb_stb_o <= 1'b1;
                    end
                end
                READ: if (wb.wb_ack_i) begin
                    state       <= WRITE;
                    wb.wb_dat_o <= wb.wb_dat_i;
                    wb.wb_adr_o <= dst;
                    wb.wb_we_o  <= 1'b1;
                end else if (expired) begin
                    state       <= ABORT;
                    done_o      <= 1'b1;
                    error_o     <= 1'b1;
                    wb.wb_cyc_o <= 1'b0;
                    wb.wb_stb_o <= 1'b0;
                    wb.wb_sel_o <= '0;
                end
                WRITE: if (wb.wb_ack_i) begin
                    cnt <= cnt - 1'b1;
                    src <= src + 1'b1;
                    dst <= dst + 1'b1;
                    wb.wb_we_o <= 1'b0;
                    if (cnt == LEN_W'(1)) begin
                        state       <= DONE;
                        done_o      <= 1'b1;
                        wb.wb_cyc_o <= 1'b0;
                        wb.wb_stb_o <= 1'b0;
                        wb.wb_sel_o <= '0;
                    end else begin
                        state       <= READ;
                        wb.wb_adr_o <= src + 1'b1;
                    end
                end else if (expired) begin
                    state       <= ABORT;
                    done_o      <= 1'b1;
                    error_o     <= 1'b1;
                    wb.wb_we_o  <= 1'b0;
                    wb.wb_cyc_o <= 1'b0;
                    wb.wb_stb_o <= 1'b0;
                    wb.wb_sel_o <= '0;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
